// File: rtl/gmii_tx_framer_if.sv
// FIFO read side and GMII transmit side of one switch port, seen from the framer.
interface gmii_tx_framer_if;
    logic [8:0] tx_dout;
    logic       tx_empty;
    logic       tx_rd_en;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    modport master (
        input  tx_dout,
        input  tx_empty,
        output tx_rd_en,
        output gmii_txd,
        output gmii_tx_en,
        output gmii_tx_er
    );

    modport slave (
        output tx_dout,
        output tx_empty,
        input  tx_rd_en,
        input  gmii_txd,
        input  gmii_tx_en,
        input  gmii_tx_er
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: drains a port TX FIFO (bit8=1 data, bit8=0 end marker),
// prepends preamble and SFD, enforces the inter-frame gap and aborts a frame
// with tx_er when the FIFO runs dry mid-frame. The FCS comes from the FIFO.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    gmii_tx_framer_if.master  bus,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underrun_cnt
);
    localparam int CNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, PREAMBLE, SFD, DATA, ERR, DRAIN, IFG
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    hold_reg, hold_next;
    logic          pending_reg, pending_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          rd;
    logic          frame_inc, underrun_inc;
    logic [7:0]    txd_next;
    logic          en_next, er_next;

    // The read strobe never fires while the FIFO is empty or during reset.
    assign bus.tx_rd_en = rd & ~sys_rst;

    // Next-state, read and counter-event decode; GMII outputs are decoded from
    // the next state so they line up with the state they belong to.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        pending_next = 1'b0;
        cnt_next     = cnt_reg;
        rd           = 1'b0;
        frame_inc    = 1'b0;
        underrun_inc = 1'b0;
        case (state_reg)
            IDLE: begin
                rd = !bus.tx_empty;
                if (rd) state_next = FETCH;
            end
            FETCH: begin
                if (bus.tx_dout[8]) begin
                    hold_next  = bus.tx_dout[7:0];
                    cnt_next   = '0;
                    state_next = PREAMBLE;
                end else begin
                    state_next = IDLE;  // stray or zero-length marker
                end
            end
            PREAMBLE: begin
                if (cnt_reg == PRE_LAST) state_next = SFD;
                else                     cnt_next   = cnt_reg + 1'b1;
            end
            SFD: begin
                rd           = !bus.tx_empty;
                pending_next = rd;
                state_next   = DATA;
            end
            DATA: begin
                if (!pending_reg) begin
                    state_next = ERR;       // current byte goes out, next is missing
                end else if (!bus.tx_dout[8]) begin
                    frame_inc  = 1'b1;      // current byte is the last one
                    cnt_next   = '0;
                    state_next = IFG;
                end else begin
                    hold_next    = bus.tx_dout[7:0];
                    rd           = !bus.tx_empty;
                    pending_next = rd;
                end
            end
            ERR: begin
                underrun_inc = 1'b1;
                state_next   = DRAIN;
            end
            DRAIN: begin
                if (pending_reg && !bus.tx_dout[8]) begin
                    cnt_next   = '0;
                    state_next = IFG;
                end else begin
                    rd           = !bus.tx_empty;
                    pending_next = rd;
                end
            end
            IFG: begin
                if (cnt_reg == IFG_LAST) state_next = IDLE;
                else                     cnt_next   = cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        en_next  = 1'b0;
        er_next  = 1'b0;
        txd_next = 8'h00;
        case (state_next)
            PREAMBLE: begin en_next = 1'b1; txd_next = 8'h55;     end
            SFD:      begin en_next = 1'b1; txd_next = 8'hD5;     end
            DATA:     begin en_next = 1'b1; txd_next = hold_next; end
            ERR:      begin en_next = 1'b1; er_next  = 1'b1;      end
            default:  ;
        endcase
    end

    // State, hold register, pending flag and registered GMII outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            hold_reg       <= 8'h00;
            pending_reg    <= 1'b0;
            cnt_reg        <= '0;
            bus.gmii_txd   <= 8'h00;
            bus.gmii_tx_en <= 1'b0;
            bus.gmii_tx_er <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            pending_reg    <= pending_next;
            cnt_reg        <= cnt_next;
            bus.gmii_txd   <= txd_next;
            bus.gmii_tx_en <= en_next;
            bus.gmii_tx_er <= er_next;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt    <= 16'h0000;
            underrun_cnt <= 16'h0000;
        end else begin
            if (frame_inc && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'h0001;
            if (underrun_inc && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer with a behavioural one-cycle-latency FIFO.
module tb_gmii_tx_framer;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;

    gmii_tx_framer_if bus ();

    gmii_tx_framer #(.PREAMBLE_LEN(7), .IFG_CYCLES(12)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .bus          (bus),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // FIFO model: memory and write pointer owned by the stimulus process,
    // read pointer and output register owned by the clocked process.
    logic [8:0] fifo_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr;
    logic [8:0] fifo_dout;
    int         viol = 0;

    assign bus.tx_empty = (wr_ptr == rd_ptr);
    assign bus.tx_dout  = fifo_dout;

    // FIFO read port; reads of an empty FIFO are counted as violations.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr    <= 8'd0;
            fifo_dout <= 9'd0;
        end else if (bus.tx_rd_en) begin
            if (bus.tx_empty) viol <= viol + 1;
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    task automatic push(input logic [8:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Per-cycle capture of the GMII side, sampled mid-cycle.
    logic       cap_en  [0:511];
    logic       cap_er  [0:511];
    logic [7:0] cap_txd [0:511];
    int         cap_n = 0;

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            if (cap_n < 512) begin
                cap_en[cap_n]  = bus.gmii_tx_en;
                cap_er[cap_n]  = bus.gmii_tx_er;
                cap_txd[cap_n] = bus.gmii_txd;
                cap_n++;
            end
        end
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < cap_n; i++) if (cap_en[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int run_len(input int idx);
        int n = 0;
        if (idx < 0) return 0;
        for (int i = idx; i < cap_n && cap_en[i] === 1'b1; i++) n++;
        return n;
    endfunction

    function automatic int count_en(input int from);
        int n = 0;
        for (int i = from; i < cap_n; i++) if (cap_en[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_er(input int from);
        int n = 0;
        for (int i = from; i < cap_n; i++) if (cap_er[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic do_reset();
        sys_rst = 1'b1;
        wr_ptr  = 8'd0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cap_n   = 0;
    endtask

    task automatic test_reset();
        #1 sys_rst = 1'b1;
        #1;
        total++; if (bus.gmii_tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", bus.gmii_tx_en); end
        total++; if (bus.gmii_tx_er !== 1'b0) begin bad++; $display("FAIL reset_tx_er: got %b want 0", bus.gmii_tx_er); end
        total++; if (bus.gmii_txd !== 8'h00) begin bad++; $display("FAIL reset_txd: got %h want 00", bus.gmii_txd); end
        total++; if (bus.tx_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.tx_rd_en); end
        total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
        total++; if (underrun_cnt !== 16'h0000) begin bad++; $display("FAIL reset_underrun_cnt: got %h want 0000", underrun_cnt); end
        do_reset();
    endtask

    task automatic test_single_frame();
        logic [7:0] exp [12] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04};
        int f;
        do_reset();
        push(9'h101); push(9'h102); push(9'h103); push(9'h104); push(9'h000);
        run_cycles(40);
        f = first_en(0);
        total++; if (f != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", f); end
        if (f < 0) f = 0;
        total++; if (run_len(f) != 12) begin bad++; $display("FAIL single_en_len: got %0d want 12", run_len(f)); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (cap_txd[f+i] !== exp[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, cap_txd[f+i], exp[i]); end
        end
        total++; if (count_en(0) != 12) begin bad++; $display("FAIL single_total_en: got %0d want 12", count_en(0)); end
        total++; if (count_er(0) != 0) begin bad++; $display("FAIL single_tx_er: got %0d want 0", count_er(0)); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
        $display("single frame: first_en=%0d frame_cnt=%0d", f, frame_cnt);
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2, errs_a, errs_b;
        do_reset();
        for (int i = 0; i < 60; i++) push({1'b1, 8'(i)});
        push(9'h000);
        for (int i = 0; i < 60; i++) push({1'b1, 8'(8'h80 + i)});
        push(9'h000);
        run_cycles(200);
        f1 = first_en(0);
        if (f1 < 0) f1 = 0;
        l1 = run_len(f1);
        f2 = first_en(f1 + l1);
        if (f2 < 0) f2 = cap_n - 1;
        l2 = run_len(f2);
        total++; if (l1 != 68) begin bad++; $display("FAIL b2b_len1: got %0d want 68", l1); end
        total++; if (l2 != 68) begin bad++; $display("FAIL b2b_len2: got %0d want 68", l2); end
        total++; if (f2 - (f1 + l1) != 14) begin bad++; $display("FAIL b2b_gap: got %0d want 14", f2 - (f1 + l1)); end
        errs_a = 0; errs_b = 0;
        for (int i = 0; i < 60; i++) begin
            if (cap_txd[f1 + 8 + i] !== 8'(i)) errs_a++;
            if (cap_txd[f2 + 8 + i] !== 8'(8'h80 + i)) errs_b++;
        end
        total++; if (errs_a != 0) begin bad++; $display("FAIL b2b_data1: got %0d wrong bytes want 0", errs_a); end
        total++; if (errs_b != 0) begin bad++; $display("FAIL b2b_data2: got %0d wrong bytes want 0", errs_b); end
        total++; if (count_er(0) != 0) begin bad++; $display("FAIL b2b_tx_er: got %0d want 0", count_er(0)); end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
        $display("back to back: len1=%0d len2=%0d gap=%0d frame_cnt=%0d", l1, l2, f2 - (f1 + l1), frame_cnt);
    endtask

    task automatic test_stray_marker();
        do_reset();
        push(9'h000);
        run_cycles(20);
        total++; if (rd_ptr !== 8'd1) begin bad++; $display("FAIL stray_reads: got %0d want 1", rd_ptr); end
        total++; if (count_en(0) != 0) begin bad++; $display("FAIL stray_tx_en: got %0d want 0", count_en(0)); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL stray_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("FAIL stray_empty: got %b want 1", bus.tx_empty); end
        $display("stray marker: reads=%0d frame_cnt=%0d", rd_ptr, frame_cnt);
    endtask

    task automatic test_underrun();
        logic [7:0] exp  [12] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                  8'hD5, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        logic [7:0] exp2 [10] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                  8'hD5, 8'h11, 8'h22};
        int f, start;
        do_reset();
        push(9'h1AA); push(9'h1BB); push(9'h1CC);
        run_cycles(24);
        f = first_en(0);
        if (f < 0) f = 0;
        total++; if (run_len(f) != 12) begin bad++; $display("FAIL underrun_en_len: got %0d want 12", run_len(f)); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (cap_txd[f+i] !== exp[i]) begin bad++; $display("FAIL underrun_byte%0d: got %h want %h", i, cap_txd[f+i], exp[i]); end
        end
        total++; if (cap_er[f+11] !== 1'b1) begin bad++; $display("FAIL underrun_er_pos: got %b want 1", cap_er[f+11]); end
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt); end
        push(9'h1DD); push(9'h1EE); push(9'h000);
        run_cycles(30);
        total++; if (count_en(0) != 12) begin bad++; $display("FAIL underrun_drain_en: got %0d want 12", count_en(0)); end
        total++; if (count_er(0) != 1) begin bad++; $display("FAIL underrun_er_count: got %0d want 1", count_er(0)); end
        total++; if (rd_ptr !== wr_ptr) begin bad++; $display("FAIL underrun_drained: got rd_ptr %0d want %0d", rd_ptr, wr_ptr); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL underrun_frame_cnt: got %0d want 0", frame_cnt); end
        start = cap_n;
        push(9'h111); push(9'h122); push(9'h000);
        run_cycles(30);
        f = first_en(start);
        total++; if (f != start + 1) begin bad++; $display("FAIL underrun_next_latency: got %0d want %0d", f, start + 1); end
        if (f < 0) f = start;
        total++; if (run_len(f) != 10) begin bad++; $display("FAIL underrun_next_len: got %0d want 10", run_len(f)); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap_txd[f+i] !== exp2[i]) begin bad++; $display("FAIL underrun_next_byte%0d: got %h want %h", i, cap_txd[f+i], exp2[i]); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL underrun_next_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (viol != 0) begin bad++; $display("FAIL empty_reads: got %0d want 0", viol); end
        $display("underrun: underrun_cnt=%0d frame_cnt=%0d", underrun_cnt, frame_cnt);
    endtask

    task automatic test_async_reset();
        logic [7:0] exp [11] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                                 8'hD5, 8'h31, 8'h32, 8'h33};
        bit hit = 0;
        int f;
        for (int i = 0; i < 8; i++) push({1'b1, 8'(8'h10 + i)});
        push(9'h000);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge sys_clk);
            if (bus.gmii_tx_en === 1'b1 && bus.gmii_txd === 8'h12) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL arst_reach_data: got timeout want byte 12"); end
        #2 sys_rst = 1'b1;
        wr_ptr = 8'd0;
        #1;
        total++; if (bus.gmii_tx_en !== 1'b0) begin bad++; $display("FAIL arst_tx_en: got %b want 0", bus.gmii_tx_en); end
        total++; if (bus.gmii_tx_er !== 1'b0) begin bad++; $display("FAIL arst_tx_er: got %b want 0", bus.gmii_tx_er); end
        total++; if (bus.gmii_txd !== 8'h00) begin bad++; $display("FAIL arst_txd: got %h want 00", bus.gmii_txd); end
        total++; if (bus.tx_rd_en !== 1'b0) begin bad++; $display("FAIL arst_rd_en: got %b want 0", bus.tx_rd_en); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL arst_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL arst_underrun_cnt: got %0d want 0", underrun_cnt); end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cap_n = 0;
        push(9'h131); push(9'h132); push(9'h133); push(9'h000);
        run_cycles(30);
        f = first_en(0);
        total++; if (f != 1) begin bad++; $display("FAIL arst_next_latency: got %0d want 1", f); end
        if (f < 0) f = 0;
        total++; if (run_len(f) != 11) begin bad++; $display("FAIL arst_next_len: got %0d want 11", run_len(f)); end
        for (int i = 0; i < 11; i++) begin
            total++;
            if (cap_txd[f+i] !== exp[i]) begin bad++; $display("FAIL arst_next_byte%0d: got %h want %h", i, cap_txd[f+i], exp[i]); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL arst_next_frame_cnt: got %0d want 1", frame_cnt); end
        $display("async reset: next frame len=%0d frame_cnt=%0d", run_len(f), frame_cnt);
    endtask

    task automatic test_saturation();
        int f;
        do_reset();
        force dut.frame_cnt = 16'hFFFE;
        @(negedge sys_clk);
        release dut.frame_cnt;
        @(negedge sys_clk);
        total++; if (frame_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %h want fffe", frame_cnt); end
        cap_n = 0;
        push(9'h141); push(9'h000);
        run_cycles(30);
        f = first_en(0);
        total++; if (run_len(f) != 9) begin bad++; $display("FAIL sat_len1: got %0d want 9", run_len(f)); end
        total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_first: got %h want ffff", frame_cnt); end
        cap_n = 0;
        push(9'h142); push(9'h000);
        run_cycles(30);
        f = first_en(0);
        total++; if (run_len(f) != 9) begin bad++; $display("FAIL sat_len2: got %0d want 9", run_len(f)); end
        total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", frame_cnt); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL sat_underrun_cnt: got %0d want 0", underrun_cnt); end
        $display("saturation: frame_cnt=%h", frame_cnt);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stray_marker();
        test_underrun();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
